// File: rtl/fbosc_seq.sv
// Two-phase non-overlapping y1/y2 sequencer with start/stop handshake,
// programmable phase length, dead time and burst count.
module fbosc_seq #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   ph_len,
  input  logic [CNT_W-1:0]   dead_len,
  input  logic [BURST_W-1:0] burst,
  output logic               y1,
  output logic               y2,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] cyc_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PH1   = 3'd1,
    S_DEAD1 = 3'd2,
    S_PH2   = 3'd3,
    S_DEAD2 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(0);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
  localparam logic [BURST_W-1:0] BURST_ZERO = BURST_W'(0);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     ph_q, ph_d;
  logic [CNT_W-1:0]     dead_q, dead_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [BURST_W-1:0]   cyc_q, cyc_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 y1_q, y1_d;
  logic                 y2_q, y2_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 eop_s;
  logic [CNT_W-1:0]     ph_last_s;
  logic [CNT_W-1:0]     dead_last_s;
  logic [CNT_W-1:0]     ph_in_last_s;

  // Next-state, counter, shadow-config and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ph_d        = ph_q;
    dead_d      = dead_q;
    burst_d     = burst_q;
    cyc_d       = cyc_q;
    stop_pend_d = stop_pend_q;
    eop_s       = 1'b0;

    // Phase length of zero behaves as one cycle.
    ph_last_s    = (ph_q == CNT_ZERO) ? CNT_ZERO : (ph_q - CNT_ONE);
    ph_in_last_s = (ph_len == CNT_ZERO) ? CNT_ZERO : (ph_len - CNT_ONE);
    dead_last_s  = dead_q - CNT_ONE;

    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          ph_d    = ph_len;
          dead_d  = dead_len;
          burst_d = burst;
          cyc_d   = BURST_ZERO;
          cnt_d   = ph_in_last_s;
          state_d = S_PH1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PH1: begin
        if (stop) stop_pend_d = 1'b1;
        else      stop_pend_d = stop_pend_q;
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (dead_q != CNT_ZERO) begin
          cnt_d   = dead_last_s;
          state_d = S_DEAD1;
        end else begin
          cnt_d   = ph_last_s;
          state_d = S_PH2;
        end
      end
      S_DEAD1: begin
        if (stop) stop_pend_d = 1'b1;
        else      stop_pend_d = stop_pend_q;
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d   = ph_last_s;
          state_d = S_PH2;
        end
      end
      S_PH2: begin
        if (stop) stop_pend_d = 1'b1;
        else      stop_pend_d = stop_pend_q;
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (dead_q != CNT_ZERO) begin
          cnt_d   = dead_last_s;
          state_d = S_DEAD2;
        end else begin
          eop_s = 1'b1;
        end
      end
      S_DEAD2: begin
        if (stop) stop_pend_d = 1'b1;
        else      stop_pend_d = stop_pend_q;
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          eop_s = 1'b1;
        end
      end
      S_DONE: begin
        stop_pend_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        stop_pend_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    // End of period: count it, then either finish or start the next one.
    // A stop seen on this very cycle still ends the run here.
    if (eop_s) begin
      cyc_d = cyc_q + BURST_ONE;
      if (((burst_q != BURST_ZERO) && (cyc_d == burst_q)) || stop_pend_q || stop) begin
        state_d = S_DONE;
      end else begin
        cnt_d   = ph_last_s;
        state_d = S_PH1;
      end
    end else begin
      cyc_d = cyc_d;
    end

    // Outputs are decoded from the next state so they leave a flop directly.
    y1_d   = (state_d == S_PH1);
    y2_d   = (state_d == S_PH2);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, counters, shadow configuration and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= CNT_ZERO;
      ph_q        <= CNT_ZERO;
      dead_q      <= CNT_ZERO;
      burst_q     <= BURST_ZERO;
      cyc_q       <= BURST_ZERO;
      stop_pend_q <= 1'b0;
      y1_q        <= 1'b0;
      y2_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      dead_q      <= dead_d;
      burst_q     <= burst_d;
      cyc_q       <= cyc_d;
      stop_pend_q <= stop_pend_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign y1      = y1_q;
  assign y2      = y2_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cyc_cnt = cyc_q;

endmodule

// File: tb/tb_fbosc_seq.sv
// Randomized bench for fbosc_seq: a per-run waveform queue model predicts
// y1/y2/busy/done/cyc_cnt every cycle.
module tb_fbosc_seq;
  localparam int CW = 4;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop;
  logic [CW-1:0] ph_len, dead_len;
  logic [BW-1:0] burst;
  logic          y1, y2, busy, done;
  logic [BW-1:0] cyc_cnt;

  int total = 0;
  int bad   = 0;

  fbosc_seq #(.CNT_W(CW), .BURST_W(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .ph_len(ph_len), .dead_len(dead_len), .burst(burst),
    .y1(y1), .y2(y2), .busy(busy), .done(done), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: 0=idle, 1=running (cur holds this cycle's waveform slot), 2=done.
  int          m_kind;
  logic [2:0]  wave_q[$];  // {end_of_period, y2, y1}
  logic [2:0]  cur;
  int          m_cyc;
  bit          m_pend;
  int          s_ph, s_dead, s_burst;

  task automatic push_period();
    int p;
    p = (s_ph == 0) ? 1 : s_ph;
    for (int i = 0; i < p; i++) wave_q.push_back(3'b001);
    for (int i = 0; i < s_dead; i++) wave_q.push_back(3'b000);
    for (int i = 0; i < p; i++) wave_q.push_back(3'b010);
    for (int i = 0; i < s_dead; i++) wave_q.push_back(3'b000);
    wave_q[wave_q.size()-1][2] = 1'b1;
  endtask

  task automatic model_reset();
    m_kind = 0; m_cyc = 0; m_pend = 0; cur = 3'b000;
    s_ph = 0; s_dead = 0; s_burst = 0;
    wave_q.delete();
  endtask

  task automatic model_step();
    if (m_kind == 0) begin
      m_pend = 0;
      if (start) begin
        s_ph = ph_len; s_dead = dead_len; s_burst = burst;
        m_cyc = 0;
        push_period();
        cur = wave_q.pop_front();
        m_kind = 1;
      end
    end else if (m_kind == 1) begin
      if (stop) m_pend = 1;
      if (cur[2]) begin
        m_cyc = (m_cyc + 1) % (1 << BW);
        if ((s_burst != 0 && m_cyc == s_burst) || m_pend) begin
          m_kind = 2;
        end else begin
          push_period();
          cur = wave_q.pop_front();
        end
      end else begin
        cur = wave_q.pop_front();
      end
    end else begin
      m_kind = 0;
      m_pend = 0;
    end
  endtask

  task automatic compare_all(input string where);
    chk({where, ".y1"},   32'(y1),      32'((m_kind == 1) && cur[0]));
    chk({where, ".y2"},   32'(y2),      32'((m_kind == 1) && cur[1]));
    chk({where, ".busy"}, 32'(busy),    32'(m_kind != 0));
    chk({where, ".done"}, 32'(done),    32'(m_kind == 2));
    chk({where, ".cyc"},  32'(cyc_cnt), 32'(m_cyc));
    chk({where, ".excl"}, 32'(y1 & y2), 32'd0);
  endtask

  int mode;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    ph_len = '0; dead_len = '0; burst = '0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      mode = (cyc / 300) % 3;
      // Drive this cycle's inputs; config is randomized every cycle so
      // mid-run changes exercise the shadow capture.
      start    = ($urandom_range(0, 3) == 0);
      stop     = (mode == 1) ? 1'b0 :
                 (mode == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 24) == 0);
      ph_len   = (mode == 1) ? CW'($urandom_range(0, 1)) : CW'($urandom_range(0, 4));
      dead_len = (mode == 1) ? CW'(0) : CW'($urandom_range(0, 2));
      burst    = (mode == 1) ? BW'(0) : BW'($urandom_range(0, 4));

      if (cyc > 20 && $urandom_range(0, 249) == 0) begin
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        #1;
        rst = 1'b0;
      end

      @(posedge clk);
      model_step();
      #1;
      compare_all("run");
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
